// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: single-outstanding imem requests, DEPTH-entry prefetch FIFO, IF/ID register.
// Optional FETCH_BYPASS_EN: a response arriving into an empty FIFO is written straight into IF/ID.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]            fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [DEPTH-1:0][31:0] fifo_pc_q, fifo_ins_q;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   outstanding_q, outstanding_d, discard_q, discard_d;
  logic                   valid_q, valid_d;
  logic [31:0]            instr_q, instr_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
  logic                   resp, grant, accept, bypass, push, pop;

  // The slot for an in-flight word is reserved up front, so a push never finds the FIFO full.
  assign imem_req  = !rst && !PCSrcE &&
                     ((count_q + CW'(outstanding_q)) < CW'(DEPTH)) &&
                     (!outstanding_q || imem_rvalid);
  assign imem_addr = rst ? RESET_PC : fetch_pc_q;
  assign resp      = imem_rvalid && outstanding_q;
  assign grant     = imem_req && imem_gnt;
  assign accept    = resp && !discard_q && !PCSrcE;

`ifdef FETCH_BYPASS_EN
  assign bypass = accept && (count_q == '0) && !StallD;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    pcd_d         = pcd_q;
    pcp4_d        = pcp4_q;
    push          = 1'b0;
    pop           = 1'b0;
    outstanding_d = grant ? 1'b1 : (resp ? 1'b0 : outstanding_q);
    if (grant) begin
      resp_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (PCSrcE) begin
      // Only a request still in flight after this edge needs its data dropped.
      fetch_pc_d = PCTargetE;
      discard_d  = outstanding_d;
      valid_d    = 1'b0;
      instr_d    = NOP;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (resp) discard_d = 1'b0;
      push = accept && !bypass;
      if (!StallD) begin
        if (count_q != '0) begin
          pop     = 1'b1;
          valid_d = 1'b1;
          instr_d = fifo_ins_q[rd_ptr_q];
          pcd_d   = fifo_pc_q[rd_ptr_q];
          pcp4_d  = fifo_pc_q[rd_ptr_q] + 32'd4;
        end else if (bypass) begin
          valid_d = 1'b1;
          instr_d = imem_rdata;
          pcd_d   = resp_pc_q;
          pcp4_d  = resp_pc_q + 32'd4;
        end else begin
          valid_d = 1'b0;
          instr_d = NOP;
        end
      end
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      valid_q       <= 1'b0;
      instr_q       <= NOP;
      pcd_q         <= '0;
      pcp4_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      pcd_q         <= pcd_d;
      pcp4_q        <= pcp4_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= resp_pc_q;
      fifo_ins_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: queue-based reference model, in-order one-deep memory model,
// directed scenarios followed by a randomized run.
module tb_fetch_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_V = 2;
`else
  localparam int FIRST_V = 3;
`endif

  logic        clk = 1'b0;
  logic        rst, PCSrcE, StallD, imem_req, imem_gnt, imem_rvalid, ValidD;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  int checks = 0, failures = 0;

  // reference model: queue of fetched words plus the architectural registers
  logic [31:0] q_pc[$], q_in[$];
  logic [31:0] m_fpc, m_rpc, m_instr, m_pcd, m_pcp4;
  logic        m_out, m_disc, m_valid, e_req;
  bit          m_init = 0;

  // memory: at most one pending request, answered after mp_cnt+1 cycles
  bit          mp = 0;
  logic [31:0] mp_addr = '0;
  int          mp_cnt = 0;

  bit          rnd = 0, c_rst = 1, c_gnt = 1, c_stall = 0, c_pcsrc = 0;
  logic [31:0] c_tgt = '0;
  int          c_lat = 0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pcd, s_pcp4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic        resp, grant, acc, nout;
    logic [31:0] ppc;
    if (rst) begin
      m_fpc = RESET_PC; m_rpc = RESET_PC; q_pc.delete(); q_in.delete();
      m_out = 0; m_disc = 0; m_valid = 0; m_instr = NOP; m_pcd = '0; m_pcp4 = '0;
      m_init = 1;
      return;
    end
    resp  = imem_rvalid && m_out;
    grant = e_req && imem_gnt;
    acc   = resp && !m_disc && !PCSrcE;
    ppc   = m_rpc;
    nout  = grant ? 1'b1 : (resp ? 1'b0 : m_out);
    if (grant) begin m_rpc = m_fpc; m_fpc = m_fpc + 32'd4; end
    if (PCSrcE) begin
      q_pc.delete(); q_in.delete();
      m_valid = 0; m_instr = NOP; m_fpc = PCTargetE; m_disc = nout;
    end else begin
      if (resp) m_disc = 0;
      if (StallD) begin
        if (acc) begin q_pc.push_back(ppc); q_in.push_back(imem_rdata); end
      end else if (q_pc.size() > 0) begin
        m_valid = 1; m_pcd = q_pc.pop_front(); m_instr = q_in.pop_front(); m_pcp4 = m_pcd + 32'd4;
        if (acc) begin q_pc.push_back(ppc); q_in.push_back(imem_rdata); end
      end else begin
`ifdef FETCH_BYPASS_EN
        if (acc) begin m_valid = 1; m_instr = imem_rdata; m_pcd = ppc; m_pcp4 = ppc + 32'd4; end
        else begin m_valid = 0; m_instr = NOP; end
`else
        m_valid = 0; m_instr = NOP;
        if (acc) begin q_pc.push_back(ppc); q_in.push_back(imem_rdata); end
`endif
      end
    end
    m_out = nout;
  endtask

  // one clock: drive, compare at negedge, advance model and memory at posedge
  task automatic cycle();
    logic [31:0] t;
    rst = rnd ? ($urandom_range(199) == 0) : c_rst;
    if (rnd) begin
      imem_gnt = ($urandom_range(99) < 70);
      StallD   = ($urandom_range(99) < 20);
      PCSrcE   = ($urandom_range(99) < 6);
      t = $urandom(); t[1:0] = 2'b00;
      PCTargetE = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : t;
    end else begin
      imem_gnt = c_gnt; StallD = c_stall; PCSrcE = c_pcsrc; PCTargetE = c_tgt;
    end
    if (mp && mp_cnt == 0) begin
      imem_rvalid = 1; imem_rdata = mp_addr;
    end else begin
      if (mp) mp_cnt--;
      imem_rvalid = rnd && !mp && ($urandom_range(9) == 0);
      imem_rdata  = $urandom();
    end
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = ValidD;
    s_instr = InstrD; s_pcd = PCD; s_pcp4 = PCPlus4D;
    if (m_init) begin
      e_req = !rst && !PCSrcE && ((q_pc.size() + (m_out ? 1 : 0)) < DEPTH) && (!m_out || imem_rvalid);
      chk("imem_req", 32'(s_req), 32'(e_req));
      chk("imem_addr", s_addr, rst ? RESET_PC : m_fpc);
      chk("ValidD", 32'(s_valid), 32'(m_valid));
      chk("InstrD", s_instr, m_instr);
      chk("PCD", s_pcd, m_pcd);
      chk("PCPlus4D", s_pcp4, m_pcp4);
    end else e_req = 0;
    @(posedge clk);
    model_edge();
    if (rst) mp = 0;
    else begin
      if (imem_rvalid && mp) mp = 0;
      if (s_req && imem_gnt) begin
        mp = 1; mp_addr = s_addr;
        mp_cnt = rnd ? int'($urandom_range(3)) : c_lat;
      end
    end
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!s_valid && n < 20) begin cycle(); n++; end
    chk(nm, 32'(n < 20), 32'd1);
  endtask

  initial begin
    int          first, n;
    logic [31:0] p, a;
    rst = 1; PCSrcE = 0; PCTargetE = '0; StallD = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    repeat (2) cycle();
    c_rst = 0;

    // startup latency and back-to-back stream
    first = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (s_valid && first < 0) first = k;
      if (first >= 0 && k - first < 6) begin
        chk("t1_stream_pcd", s_pcd, 32'(4 * (k - first)));
        chk("t1_stream_valid", 32'(s_valid), 32'd1);
      end
    end
    chk("t1_first_valid_cycle", 32'(first), 32'(FIRST_V));

    // decode stall fills the FIFO and gates requests
    p = m_pcd;
    c_stall = 1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t2_frozen_pcd", s_pcd, p);
    end
    chk("t2_model_full", 32'(q_pc.size()), 32'd4);
    chk("t2_req_gated", 32'(s_req), 32'd0);
    c_stall = 0;
    cycle();
    cycle();
    chk("t2_resume_pcd", s_pcd, p + 32'd4);
    chk("t2_resume_valid", 32'(s_valid), 32'd1);

    // redirect while a request is in flight
    c_lat = 2; n = 0;
    while (!(m_out && mp && mp_cnt != 0) && n < 10) begin cycle(); n++; end
    chk("t3_inflight_found", 32'(n < 10), 32'd1);
    c_pcsrc = 1; c_tgt = 32'h100;
    cycle();
    c_pcsrc = 0; c_lat = 0;
    cycle();
    chk("t3_bubble", 32'(s_valid), 32'd0);
    wait_valid("t3_wait_target");
    chk("t3_target_pcd", s_pcd, 32'h100);
    cycle();
    chk("t3_target_next", s_pcd, 32'h104);

    // grant withheld for three cycles: request and address hold
    a = m_fpc;
    c_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t4_req_held", 32'(s_req), 32'd1);
      chk("t4_addr_held", s_addr, a);
    end
    c_gnt = 1;
    cycle();
    chk("t4_single_grant", m_fpc, a + 32'd4);
    repeat (4) cycle();

    // flush beats stall, target near the top of the address space
    c_pcsrc = 1; c_stall = 1; c_tgt = 32'hFFFF_FFF8;
    cycle();
    c_pcsrc = 0; c_stall = 0;
    cycle();
    chk("t5_bubble", 32'(s_valid), 32'd0);
    chk("t5_bubble_nop", s_instr, NOP);
    wait_valid("t5_wait_target");
    chk("t5_pcd0", s_pcd, 32'hFFFF_FFF8);
    cycle();
    chk("t5_pcd1", s_pcd, 32'hFFFF_FFFC);
    chk("t5_pcp4_wrap", s_pcp4, 32'h0);
    cycle();
    chk("t5_pcd_wrap", s_pcd, 32'h0);

    // one-cycle reset mid-stream
    repeat (3) cycle();
    c_rst = 1;
    cycle();
    c_rst = 0;
    cycle();
    chk("t6_valid", 32'(s_valid), 32'd0);
    chk("t6_nop", s_instr, NOP);
    chk("t6_pcd", s_pcd, 32'h0);
    chk("t6_req", 32'(s_req), 32'd1);
    chk("t6_addr", s_addr, RESET_PC);

    // randomized traffic against the model
    rnd = 1;
    repeat (3000) cycle();
    rnd = 0;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction fetch front end with a prefetch buffer, feeding the decode stage of the 5-stage RV32 pipeline. Issues word fetches to instruction memory over a req/gnt/rvalid handshake, buffers returned instructions with their PCs in a small FIFO, and drives the IF/ID register (InstrD, PCD, PCPlus4D, ValidD). Honours decode stalls from the hazard unit and branch/jump redirects from execute (PCSrcE/PCTargetE), discarding wrong-path fetches.

## Interface
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- PCSrcE  in  1  redirect request from execute
- PCTargetE  in  32  redirect target
- StallD  in  1  hold IF/ID register
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch word address (byte address, bits[1:0]=0)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid (≥1 cycle after gnt, in order)
- imem_rdata  in  32  instruction word
- InstrD  out  32  instruction to decode
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD + 4
- ValidD  out  1  InstrD is a real instruction (0 = bubble)

## Operation
- State: fetch_pc (32), FIFO of {pc, instr} with count 0..DEPTH, outstanding (1 bit, max one in-flight request), discard (1 bit, in-flight request is wrong-path), IF/ID register.
- Reset (rst=1 at edge): fetch_pc=RESET_PC, count=0, outstanding=0, discard=0, ValidD=0, InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0. While rst=1: imem_req=0; imem_addr=RESET_PC.
- Request: imem_req = !rst && !PCSrcE && (count + outstanding < DEPTH) && (!outstanding || imem_rvalid). imem_addr = fetch_pc. On imem_req && imem_gnt: outstanding=1, resp_pc=fetch_pc, fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC → 0). An ungranted request may be withdrawn only by PCSrcE; otherwise req and addr hold until gnt.
- Response: imem_rvalid with outstanding=1 clears outstanding (unless a new grant sets it the same cycle). If discard=0 and PCSrcE=0, push {resp_pc, imem_rdata}; otherwise drop and clear discard. imem_rvalid with outstanding=0 is ignored.
- IF/ID update, priority order:
  1. PCSrcE=1: ValidD=0, InstrD=NOP; FIFO flushed (count=0); fetch_pc=PCTargetE; discard=outstanding. Overrides StallD.
  2. StallD=1: IF/ID holds; no pop.
  3. Else FIFO non-empty: pop head into InstrD/PCD, PCPlus4D=pc+4, ValidD=1. Empty: ValidD=0, InstrD=NOP, PCD/PCPlus4D hold.
- Push and pop in the same cycle legal at any count; FIFO never overflows because the request gate reserves the slot.

## Timing
- Memory with gnt=1 and rvalid one cycle after gnt; first cycle with rst=0 = cycle 0: req @0, rvalid @1, FIFO non-empty @2, ValidD=1 with PCD=RESET_PC @3. Steady state one instruction per cycle.
- Redirect: PCSrcE in cycle n → ValidD=0 in n+1; req for PCTargetE earliest n+1 (n+2 if a stale request is in flight); first target instruction on ValidD at n+4 best case.
- Combinational paths: imem_rvalid→imem_req, PCSrcE→imem_req. All other outputs registered.
- Reset mid-operation: all state cleared in one edge; memory must be reset together with this block, so no response from pre-reset requests arrives.

## Configuration
- FETCH_BYPASS_EN defined: when FIFO is empty, response is accepted (not discarded, PCSrcE=0) and StallD=0, the word is written directly into IF/ID instead of pushed; ValidD at cycle 2 after reset and redirect latency shrinks by one. Otherwise buffered and popped as above.
- Not defined: every instruction passes through the FIFO; timings as stated.

## Test plan
- Reset, gnt=1, 1-cycle memory returning rdata=addr: PCD=0,4,8,… on consecutive cycles, first ValidD=1 at cycle 3 (cycle 2 with FETCH_BYPASS_EN), InstrD==PCD.
- StallD=1 for 6 cycles mid-stream: IF/ID frozen, count reaches 4, imem_req=0; after release PCD continues +4 with no gap or duplicate.
- PCSrcE=1, PCTargetE=0x100 while request in flight: next ValidD=0, stale rdata dropped, next valid PCD=0x100, then 0x104.
- gnt held low 3 cycles: imem_req=1, imem_addr constant; single grant, exactly one FIFO push.
- PCSrcE=1 and StallD=1 same cycle: flush wins, ValidD=0 next cycle, fetch resumes at PCTargetE.
- rst=1 asserted mid-stream for one cycle: next cycle ValidD=0, InstrD=0x00000013, PCD=0, first request to RESET_PC.
